pb_arbiter: RTL and testbench

- Input-conditioning stage ahead of the tug-of-war round logic.
- Takes both raw pushbuttons and, for each, synchronises, debounces and edge-detects it.
- Arbitrates which player pressed first within a round and emits single-cycle left, right or tie pulses.
- Those pulses feed the scorer/round controller. After one decision per round the block locks until the round controller clears it.

---
 rtl/tow_pkg.sv | 27 ++
 rtl/pb_debounce.sv | 68 ++++++
 rtl/pb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_pb_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tow_pkg
//  Purpose  : Shared types, defaults and helpers for the tug-of-war input
//             conditioning blocks (arbiter state encoding, counter widths).
//  Revision : 1.0 - initial release
// ============================================================================
package tow_pkg;

    localparam int DEB_CYCLES_DEF = 16;
    localparam int TIE_WIN_DEF    = 4;

    // Arbiter states; width fixed so the encoding is stable across tools
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        WAIT_R = 2'd2,
        LOCK   = 2'd3
    } pb_state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pb_debounce
//  Purpose  : One pushbutton channel: two-flop synchroniser, debounce counter
//             and rising-edge detector on the debounced level.
//  Revision : 1.0 - initial release
// ============================================================================
module pb_debounce
    import tow_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int            c_cnt_w   = cnt_width(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    // Flip the level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the level for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign level = r_level;
    assign rise  = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/pb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pb_arbiter
//  Purpose  : Conditions both pushbuttons and decides, once per round, which
//             player pressed first (or a tie inside the TIE_WIN window).
//             Emits single-cycle left/right/tie pulses, then locks until clr.
//  Options  : PBC_AUTOREARM_EN - when defined, LOCK also releases to IDLE once
//             both debounced levels have been low for DEB_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module pb_arbiter
    import tow_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TIE_WIN    = TIE_WIN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl_raw,
    input  logic pbr_raw,
    input  logic arm,
    input  logic clr,
    output logic pl_pulse,
    output logic pr_pulse,
    output logic tie_pulse,
    output logic pl_level,
    output logic pr_level,
    output logic locked
);

    // Window counter holds TIE_WIN down to 1, so it needs TIE_WIN+1 codes
    localparam int                 c_win_w    = cnt_width(TIE_WIN + 1);
    localparam logic [c_win_w-1:0] c_win_load = c_win_w'(TIE_WIN);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(1);

    logic w_pl_level;
    logic w_pr_level;
    logic w_pl_rise;
    logic w_pr_rise;

    pb_state_t          r_state;
    logic [c_win_w-1:0] r_win;
    logic               r_pl;
    logic               r_pr;
    logic               r_tie;
    logic               r_locked;

`ifdef PBC_AUTOREARM_EN
    localparam int                 c_idle_w   = cnt_width(DEB_CYCLES);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(DEB_CYCLES - 1);
    logic [c_idle_w-1:0] r_idle_cnt;
`endif

    pb_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_l (
        .clk   (clk),
        .rst   (rst),
        .raw   (pbl_raw),
        .level (w_pl_level),
        .rise  (w_pl_rise)
    );

    pb_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_r (
        .clk   (clk),
        .rst   (rst),
        .raw   (pbr_raw),
        .level (w_pr_level),
        .rise  (w_pr_rise)
    );

    // Round arbitration: first rise opens the tie window, timeout names the winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_win      <= '0;
            r_pl       <= 1'b0;
            r_pr       <= 1'b0;
            r_tie      <= 1'b0;
            r_locked   <= 1'b0;
`ifdef PBC_AUTOREARM_EN
            r_idle_cnt <= '0;
`endif
        end else begin
            // Pulses are single-cycle unless a decision re-asserts them below
            r_pl  <= 1'b0;
            r_pr  <= 1'b0;
            r_tie <= 1'b0;

            if (clr) begin
                r_state    <= IDLE;
                r_win      <= '0;
                r_locked   <= 1'b0;
`ifdef PBC_AUTOREARM_EN
                r_idle_cnt <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (arm) begin
                            if (w_pl_rise && w_pr_rise) begin
                                r_tie    <= 1'b1;
                                r_state  <= LOCK;
                                r_locked <= 1'b1;
                            end else if (w_pl_rise) begin
                                r_win   <= c_win_load;
                                r_state <= WAIT_R;
                            end else if (w_pr_rise) begin
                                r_win   <= c_win_load;
                                r_state <= WAIT_L;
                            end
                        end
                    end

                    WAIT_R: begin
                        if (!arm) begin
                            r_win   <= '0;
                            r_state <= IDLE;
                        end else if (w_pr_rise) begin
                            r_tie    <= 1'b1;
                            r_win    <= '0;
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end else if (r_win == c_win_last) begin
                            r_pl     <= 1'b1;
                            r_win    <= '0;
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end else begin
                            r_win <= r_win - 1'b1;
                        end
                    end

                    WAIT_L: begin
                        if (!arm) begin
                            r_win   <= '0;
                            r_state <= IDLE;
                        end else if (w_pl_rise) begin
                            r_tie    <= 1'b1;
                            r_win    <= '0;
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end else if (r_win == c_win_last) begin
                            r_pr     <= 1'b1;
                            r_win    <= '0;
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end else begin
                            r_win <= r_win - 1'b1;
                        end
                    end

                    LOCK: begin
`ifdef PBC_AUTOREARM_EN
                        // Both buttons released long enough: open a new round
                        if (!w_pl_level && !w_pr_level) begin
                            if (r_idle_cnt == c_idle_max) begin
                                r_idle_cnt <= '0;
                                r_state    <= IDLE;
                                r_locked   <= 1'b0;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 1'b1;
                            end
                        end else begin
                            r_idle_cnt <= '0;
                        end
`else
                        r_locked <= 1'b1;
`endif
                    end

                    default: begin
                        r_state  <= IDLE;
                        r_win    <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pl_pulse  = r_pl;
    assign pr_pulse  = r_pr;
    assign tie_pulse = r_tie;
    assign pl_level  = w_pl_level;
    assign pr_level  = w_pr_level;
    assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pb_arbiter
//  Purpose  : Self-checking bench for pb_arbiter (DEB_CYCLES=4, TIE_WIN=3).
//             Expected pulses (kind + cycle) are queued as stimulus is applied
//             and matched against every pulse the DUT produces.
//  Options  : PBC_AUTOREARM_EN selects the auto-rearm expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pb_arbiter;

    localparam int DEB = 4;
    localparam int TW  = 3;
    // Raw press to single-press pulse: 2 sync + DEB debounce + TW+1 window
    localparam int LAT = 2 + DEB + TW + 1;

    localparam int K_PL  = 1;
    localparam int K_PR  = 2;
    localparam int K_TIE = 3;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pbl_raw = 1'b0;
    logic pbr_raw = 1'b0;
    logic arm = 1'b0;
    logic clr = 1'b0;
    logic pl_pulse, pr_pulse, tie_pulse, pl_level, pr_level, locked;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    pb_arbiter #(
        .DEB_CYCLES (DEB),
        .TIE_WIN    (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pbl_raw   (pbl_raw),
        .pbr_raw   (pbr_raw),
        .arm       (arm),
        .clr       (clr),
        .pl_pulse  (pl_pulse),
        .pr_pulse  (pr_pulse),
        .tie_pulse (tie_pulse),
        .pl_level  (pl_level),
        .pr_level  (pr_level),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Release buttons, let levels fall, then clear the round
    task automatic round_clear();
        pbl_raw = 1'b0;
        pbr_raw = 1'b0;
        cycles(8);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        cycles(2);
    endtask

    // Scoreboard: every pulse must match the head of the expectation queue
    task automatic monitor();
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (rst && (pl_pulse || pr_pulse || tie_pulse)) begin
                checks++;
                if ($countones({pl_pulse, pr_pulse, tie_pulse}) != 1) kind = 0;
                else if (pl_pulse) kind = K_PL;
                else if (pr_pulse) kind = K_PR;
                else kind = K_TIE;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: kind %0d at cycle %0d, required none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e.kind || cyc !== e.at) begin
                        errors++;
                        $display("FAIL pulse_match: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 kind, cyc, e.kind, e.at);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        cycles(2);
        checks++;
        if ({pl_pulse, pr_pulse, tie_pulse, pl_level, pr_level, locked} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {pl_pulse, pr_pulse, tie_pulse, pl_level, pr_level, locked});
        end
        rst = 1'b1;
        cycles(2);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_locked: got %b, required 0", locked);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        arm = 1'b1;
        pbl_raw = 1'b1;
        cycles(3);
        pbl_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            if (pl_level) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL glitch: level_seen %b locked %b, required 0 0", seen, locked);
        end
    endtask

    task automatic test_single();
        int n;
        n = cyc;
        pbl_raw = 1'b1;
        push_exp(K_PL, n + LAT);
        cycles(5);
        checks++;
        if (pl_level !== 1'b0) begin
            errors++;
            $display("FAIL single_level_early: got %b at +5, required 0", pl_level);
        end
        cycles(1);
        checks++;
        if (pl_level !== 1'b1) begin
            errors++;
            $display("FAIL single_level_rise: got %b at +6, required 1", pl_level);
        end
        cycles(6);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL single_locked: got %b, required 1", locked);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_drain: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        round_clear();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL single_clr: locked %b, required 0", locked);
        end
    endtask

    task automatic test_tie();
        int n;
        n = cyc;
        pbr_raw = 1'b1;
        cycles(2);
        pbl_raw = 1'b1;
        push_exp(K_TIE, n + 2 + 2 + DEB + 1);
        cycles(12);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL tie_locked: got %b, required 1", locked);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL tie_drain: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        round_clear();
    endtask

    task automatic test_late_and_lock();
        int n;
        n = cyc;
        pbl_raw = 1'b1;
        cycles(5);
        pbr_raw = 1'b1;
        push_exp(K_PL, n + LAT);
        cycles(10);
        // Toggle right while locked: nothing may be emitted
        pbr_raw = 1'b0;
        cycles(8);
        pbr_raw = 1'b1;
        cycles(10);
        checks++;
        if (locked !== 1'b1 || pr_level !== 1'b1) begin
            errors++;
            $display("FAIL late_locked: locked %b pr_level %b, required 1 1", locked, pr_level);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL late_drain: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL late_clr: locked %b, required 0", locked);
        end
        // Buttons still held through clr: no new rise, stays unlocked
        cycles(8);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL late_held: locked %b, required 0", locked);
        end
        pbl_raw = 1'b0;
        pbr_raw = 1'b0;
        cycles(8);
    endtask

    task automatic test_window_edge();
        int n;
        for (int d = TW; d <= TW + 1; d++) begin
            n = cyc;
            pbl_raw = 1'b1;
            cycles(d);
            pbr_raw = 1'b1;
            // Last cycle inside the window ties, one later is a left win
            push_exp((d <= TW) ? K_TIE : K_PL, n + LAT);
            cycles(14);
            checks++;
            if (exp_q.size() !== 0) begin
                errors++;
                $display("FAIL window_d%0d_drain: %0d pulses missing, required 0", d, exp_q.size());
                exp_q.delete();
            end
            round_clear();
        end
    endtask

    task automatic test_arm();
        int n;
        arm = 1'b0;
        pbl_raw = 1'b1;
        pbr_raw = 1'b1;
        cycles(12);
        checks++;
        if (pl_level !== 1'b1 || pr_level !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL arm_off: levels %b%b locked %b, required 11 0", pl_level, pr_level, locked);
        end
        arm = 1'b1;
        cycles(8);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL arm_raise_held: locked %b, required 0", locked);
        end
        pbl_raw = 1'b0;
        pbr_raw = 1'b0;
        cycles(8);
        n = cyc;
        pbr_raw = 1'b1;
        push_exp(K_PR, n + LAT);
        cycles(12);
        checks++;
        if (locked !== 1'b1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL arm_repress: locked %b pending %0d, required 1 0", locked, exp_q.size());
            exp_q.delete();
        end
        round_clear();
        // Drop arm inside the window: round aborts silently
        pbl_raw = 1'b1;
        cycles(8);
        arm = 1'b0;
        cycles(4);
        arm = 1'b1;
        cycles(6);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort: locked %b, required 0", locked);
        end
        round_clear();
    endtask

    task automatic test_reset_midwait();
        pbl_raw = 1'b1;
        cycles(8);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({pl_pulse, pr_pulse, tie_pulse, pl_level, pr_level, locked} !== 6'b0) begin
            errors++;
            $display("FAIL midwait_reset: got %b, required 000000",
                     {pl_pulse, pr_pulse, tie_pulse, pl_level, pr_level, locked});
        end
        @(negedge clk);
        pbl_raw = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(15);
        checks++;
        if (locked !== 1'b0 || pl_level !== 1'b0) begin
            errors++;
            $display("FAIL midwait_after: locked %b pl_level %b, required 0 0", locked, pl_level);
        end
    endtask

    task automatic test_lock_release();
        int n;
        n = cyc;
        pbl_raw = 1'b1;
        push_exp(K_PL, n + LAT);
        cycles(12);
        pbl_raw = 1'b0;
`ifdef PBC_AUTOREARM_EN
        // Level falls at +18; four consecutive low samples end LOCK at +22
        cycles(9);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL rearm_early: locked %b at +21, required 1", locked);
        end
        cycles(1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL rearm_release: locked %b at +22, required 0", locked);
        end
        n = cyc;
        pbr_raw = 1'b1;
        push_exp(K_PR, n + LAT);
        cycles(12);
`else
        cycles(15);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold: locked %b after release, required 1", locked);
        end
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL lock_release_drain: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        round_clear();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_glitch();
        test_single();
        test_tie();
        test_late_and_lock();
        test_window_edge();
        test_arm();
        test_reset_midwait();
        test_lock_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
